color_out_stage: RTL and testbench
==================================

Name: color_out_stage

Overview:
- Video-side consumer of the colour RAM's 9-bit palette word.
- Samples the colour word once per pixel and decodes the inverted 3:3:3 format into 8-bit RGB.
- Delays the raw sync and blank inputs so they line up with the registered colour-RAM read, forces black while blanking, and drives DE.
- Sits between the colour memory output and the MiSTer video/scaler interface.

Parameters:
- DELAY, 1, pixel strobes by which HSYNC/VSYNC/HBLANK/VBLANK are delayed before the output register (0..4 legal).
- INVERT, 1, 1 = palette bits stored active-low (complemented before decode); 0 = stored active-high.

Ports:
- CLK10  in  1  system clock, 10 MHz.
- RESETn  in  1  synchronous reset, active-low.
- CLK5n  in  1  pixel phase; a pixel strobe (pix_stb) is any CLK10 rising edge where CLK5n==0.
- COLOR  in  9  palette word from colour RAM: [8:6] red, [5:3] green, [2:0] blue.
- HSYNC  in  1  raw horizontal sync, active-high.
- VSYNC  in  1  raw vertical sync, active-high.
- HBLANK  in  1  raw horizontal blank, active-high.
- VBLANK  in  1  raw vertical blank, active-high.
- R  out  8  red.
- G  out  8  green.
- B  out  8  blue.
- HS  out  1  aligned horizontal sync.
- VS  out  1  aligned vertical sync.
- HB  out  1  aligned horizontal blank.
- VB  out  1  aligned vertical blank.
- DE  out  1  display enable = ~(HB|VB).

Behaviour:
- Clock and reset:
  - Single clock domain, CLK10. Reset is synchronous, active-low (RESETn).
  - Every register advances only on pix_stb, except reset, which acts on any CLK10 edge.
- Reset values:
  - R=G=B=0, HS=VS=0, HB=VB=1, DE=0.
  - Delay pipeline stages: sync=0, blank=1.
  - Odd-line flag = 0.
- Sync/blank delay:
  - 4-bit vector {HSYNC,VSYNC,HBLANK,VBLANK} shifts through DELAY stages on each pix_stb.
  - DELAY=0 means the inputs feed the output register directly.
- Colour decode:
  - c = INVERT ? ~COLOR : COLOR.
  - Each 3-bit field f expands to {f, f, f[2:1]} (000->0x00, 111->0xFF, 100->0x92).
- Output register, on pix_stb:
  - HS/VS/HB/VB load the last delay stage.
  - DE loads ~(blank_hb|blank_vb) from the same stage.
  - R/G/B load the expanded colour, or 0 if that stage's HB or VB is 1.
- Latency:
  - COLOR sampled at strobe n appears on R/G/B after strobe n.
  - A sync/blank edge sampled at strobe n appears after strobe n+DELAY.
- Pixel strobe timing:
  - Between strobes, all outputs hold.
  - CLK5n held high stalls the block indefinitely with outputs frozen.
  - CLK5n held low makes every CLK10 edge a strobe (legal, used by bench).
- Reset mid-line: outputs go to reset values on the next CLK10 edge, regardless of CLK5n; the pipeline refills with blank after release.
- Simultaneous HBLANK and VBLANK: blank wins, colour output stays 0.
- A COLOR change during blank is not visible.

Optional Feature:
- Macro: COLOR_OUT_SCANDIM_EN.
- When defined:
  - An odd-line flag toggles on each rising edge of the delayed HBLANK (edge detected in the pix_stb domain).
  - The flag clears to 0 on each rising edge of the delayed VBLANK.
  - While the flag is 1, each 8-bit R/G/B value is shifted right by 1 (0xFF->0x7F) before the output register.
  - Blanking still forces 0.
- When undefined: no flag or edge-detect logic exists, and outputs are exactly as above.

Test Plan:
1. Reset release: RESETn low for 3 CLK10 cycles with COLOR=0x000 -> R/G/B=0, HB=VB=1, DE=0 during reset; with blanks low, the first valid DE=1 comes DELAY+1 strobes after release.
2. Decode with INVERT=1, blanks low: COLOR=0x000 -> R=G=B=0xFF. COLOR=0x1FF -> R=G=B=0x00. COLOR=0x0C7 (~=0x138: r=4, g=7, b=0) -> R=0x92, G=0xFF, B=0x00. Each result one strobe after sampling.
3. Alignment with DELAY=2: HBLANK rises at strobe 10 while COLOR=0x000 -> HB=1 and RGB=0 after strobe 12; RGB=0xFFFFFF after strobes 10 and 11.
4. Stall: CLK5n held high for 20 CLK10 cycles while COLOR toggles -> R/G/B/HS/VS/DE do not change.
5. Mid-line reset: RESETn low for one CLK10 cycle during active video (DE=1, RGB=0xFFFFFF) -> the next edge gives RGB=0, DE=0, HB=1.
6. With COLOR_OUT_SCANDIM_EN, COLOR=0x000, INVERT=1: line 0 RGB=0xFF, line 1 RGB=0x7F, line 2 RGB=0xFF; after a VBLANK pulse the first line is 0xFF again.

Source files
------------

// File: rtl/color_out_stage.sv
// Colour RAM output stage: decodes the 9-bit 3:3:3 palette word to 8-bit RGB and aligns sync/blank with it.
// Optional half-brightness on odd scanlines is compiled in with `define COLOR_OUT_SCANDIM_EN.
module color_out_stage #(
    parameter int DELAY  = 1,
    parameter bit INVERT = 1'b1
) (
    input  logic       CLK10,
    input  logic       RESETn,
    input  logic       CLK5n,
    input  logic [8:0] COLOR,
    input  logic       HSYNC,
    input  logic       VSYNC,
    input  logic       HBLANK,
    input  logic       VBLANK,
    output logic [7:0] R,
    output logic [7:0] G,
    output logic [7:0] B,
    output logic       HS,
    output logic       VS,
    output logic       HB,
    output logic       VB,
    output logic       DE
);

    // Sync/blank vector layout is {hsync, vsync, hblank, vblank}; reset state is "no sync, blanked".
    localparam logic [3:0] SB_RESET = 4'b0011;

    logic       w_pixStb;
    logic [3:0] w_sbIn;
    logic [3:0] w_sbDly;
    logic [8:0] w_color;
    logic [7:0] w_redFull;
    logic [7:0] w_greenFull;
    logic [7:0] w_blueFull;
    logic [7:0] w_red;
    logic [7:0] w_green;
    logic [7:0] w_blue;
    logic       w_blank;

    logic [7:0] r_red;
    logic [7:0] r_green;
    logic [7:0] r_blue;
    logic       r_hs;
    logic       r_vs;
    logic       r_hb;
    logic       r_vb;
    logic       r_de;

    function automatic logic [7:0] expand3(input logic [2:0] f);
        return {f, f, f[2:1]};
    endfunction

    assign w_pixStb = ~CLK5n;
    assign w_sbIn   = {HSYNC, VSYNC, HBLANK, VBLANK};

    generate
        if (DELAY == 0) begin : g_noDelay
            assign w_sbDly = w_sbIn;
        end else begin : g_delay
            logic [3:0] r_sbPipe [DELAY];

            always_ff @(posedge CLK10) begin
                if (!RESETn) begin
                    for (int i = 0; i < DELAY; i++) begin
                        r_sbPipe[i] <= SB_RESET;
                    end
                end else if (w_pixStb) begin
                    r_sbPipe[0] <= w_sbIn;
                    for (int i = 1; i < DELAY; i++) begin
                        r_sbPipe[i] <= r_sbPipe[i-1];
                    end
                end
            end

            assign w_sbDly = r_sbPipe[DELAY-1];
        end
    endgenerate

    assign w_color     = INVERT ? ~COLOR : COLOR;
    assign w_redFull   = expand3(w_color[8:6]);
    assign w_greenFull = expand3(w_color[5:3]);
    assign w_blueFull  = expand3(w_color[2:0]);
    assign w_blank     = w_sbDly[1] | w_sbDly[0];

`ifdef COLOR_OUT_SCANDIM_EN
    logic r_oddLine;
    logic r_hbPrev;
    logic r_vbPrev;

    // Line parity follows the delayed blanks so it flips exactly between visible lines; a frame start wins.
    always_ff @(posedge CLK10) begin
        if (!RESETn) begin
            r_oddLine <= 1'b0;
            r_hbPrev  <= 1'b1;
            r_vbPrev  <= 1'b1;
        end else if (w_pixStb) begin
            r_hbPrev <= w_sbDly[1];
            r_vbPrev <= w_sbDly[0];
            if (w_sbDly[0] && !r_vbPrev) begin
                r_oddLine <= 1'b0;
            end else if (w_sbDly[1] && !r_hbPrev) begin
                r_oddLine <= ~r_oddLine;
            end
        end
    end

    assign w_red   = r_oddLine ? {1'b0, w_redFull[7:1]}   : w_redFull;
    assign w_green = r_oddLine ? {1'b0, w_greenFull[7:1]} : w_greenFull;
    assign w_blue  = r_oddLine ? {1'b0, w_blueFull[7:1]}  : w_blueFull;
`else
    assign w_red   = w_redFull;
    assign w_green = w_greenFull;
    assign w_blue  = w_blueFull;
`endif

    always_ff @(posedge CLK10) begin
        if (!RESETn) begin
            r_red   <= 8'h00;
            r_green <= 8'h00;
            r_blue  <= 8'h00;
            r_hs    <= 1'b0;
            r_vs    <= 1'b0;
            r_hb    <= 1'b1;
            r_vb    <= 1'b1;
            r_de    <= 1'b0;
        end else if (w_pixStb) begin
            r_red   <= w_blank ? 8'h00 : w_red;
            r_green <= w_blank ? 8'h00 : w_green;
            r_blue  <= w_blank ? 8'h00 : w_blue;
            r_hs    <= w_sbDly[3];
            r_vs    <= w_sbDly[2];
            r_hb    <= w_sbDly[1];
            r_vb    <= w_sbDly[0];
            r_de    <= ~w_blank;
        end
    end

    assign R  = r_red;
    assign G  = r_green;
    assign B  = r_blue;
    assign HS = r_hs;
    assign VS = r_vs;
    assign HB = r_hb;
    assign VB = r_vb;
    assign DE = r_de;

endmodule

// File: tb/tb_color_out_stage.sv
// Testbench for color_out_stage (DELAY=2, INVERT=1): scoreboard of expected output words per pixel strobe.
// Scanline dimming scenario runs when COLOR_OUT_SCANDIM_EN is defined.
module tb_color_out_stage;

    localparam int DELAY = 2;
    // {R,G,B,HS,VS,HB,VB,DE} while in reset
    localparam logic [28:0] RST_OUT = {24'h000000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

    logic       CLK10;
    logic       RESETn;
    logic       CLK5n;
    logic [8:0] COLOR;
    logic       HSYNC, VSYNC, HBLANK, VBLANK;
    logic [7:0] R, G, B;
    logic       HS, VS, HB, VB, DE;
    logic [28:0] outv;

    int checks;
    int errors;

    logic [28:0] sbq[$];
    logic [3:0]  hist[$];
    logic [28:0] lastExp;
    logic [7:0]  expTab [8];
    logic        sdFlag, sdHbPrev, sdVbPrev;

    color_out_stage #(.DELAY(DELAY), .INVERT(1'b1)) dut (
        .CLK10(CLK10), .RESETn(RESETn), .CLK5n(CLK5n), .COLOR(COLOR),
        .HSYNC(HSYNC), .VSYNC(VSYNC), .HBLANK(HBLANK), .VBLANK(VBLANK),
        .R(R), .G(G), .B(B), .HS(HS), .VS(VS), .HB(HB), .VB(VB), .DE(DE)
    );

    assign outv = {R, G, B, HS, VS, HB, VB, DE};

    initial begin
        CLK10 = 1'b0;
        forever #5 CLK10 = ~CLK10;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: run did not finish, got timeout, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic model_reset();
        hist = {};
        for (int i = 0; i < DELAY; i++) hist.push_back(4'b0011);
        sbq = {};
        sdFlag   = 1'b0;
        sdHbPrev = 1'b1;
        sdVbPrev = 1'b1;
        lastExp  = RST_OUT;
    endtask

    // One pixel strobe: drive inputs, predict the output word, advance one CLK10 edge.
    task automatic strobe(input logic [8:0] col, input logic [3:0] sb);
        logic [3:0] d;
        logic [8:0] c;
        logic [7:0] r, g, b;
        COLOR = col;
        {HSYNC, VSYNC, HBLANK, VBLANK} = sb;
        CLK5n = 1'b0;
        if (DELAY == 0) d = sb;
        else begin
            d = hist.pop_front();
            hist.push_back(sb);
        end
        c = ~col;
        r = expTab[c[8:6]];
        g = expTab[c[5:3]];
        b = expTab[c[2:0]];
`ifdef COLOR_OUT_SCANDIM_EN
        if (sdFlag) begin
            r = r >> 1;
            g = g >> 1;
            b = b >> 1;
        end
        if (d[0] && !sdVbPrev) sdFlag = 1'b0;
        else if (d[1] && !sdHbPrev) sdFlag = ~sdFlag;
        sdHbPrev = d[1];
        sdVbPrev = d[0];
`endif
        if (d[1] || d[0]) begin
            r = 8'h00;
            g = 8'h00;
            b = 8'h00;
        end
        sbq.push_back({r, g, b, d, ~(d[1] | d[0])});
        @(posedge CLK10);
        #1;
    endtask

    task automatic test_reset();
        logic [28:0] exp;
        RESETn = 1'b0;
        CLK5n  = 1'b0;
        COLOR  = 9'h000;
        {HSYNC, VSYNC, HBLANK, VBLANK} = 4'b0000;
        for (int i = 0; i < 3; i++) begin
            @(posedge CLK10);
            #1;
            checks++;
            if (outv !== RST_OUT) begin
                errors++;
                $display("[TB] FAIL reset_state: got %h required %h", outv, RST_OUT);
            end
        end
        RESETn = 1'b1;
        model_reset();
        for (int i = 1; i <= DELAY + 2; i++) begin
            strobe(9'h000, 4'b0000);
            exp = sbq.pop_front();
            checks++;
            if (outv !== exp) begin
                errors++;
                $display("[TB] FAIL reset_release strobe %0d: got %h required %h", i, outv, exp);
            end
            checks++;
            if (DE !== (i >= DELAY + 1)) begin
                errors++;
                $display("[TB] FAIL first_de strobe %0d: got %b required %b", i, DE, (i >= DELAY + 1));
            end
            lastExp = exp;
        end
    endtask

    task automatic test_decode();
        logic [28:0] exp;
        logic [8:0]  cols [6];
        cols[0] = 9'h000;
        cols[1] = 9'h1FF;
        cols[2] = 9'h0C7;
        cols[3] = 9'h0A5;
        cols[4] = 9'($urandom);
        cols[5] = 9'($urandom);
        for (int i = 0; i < 6; i++) begin
            strobe(cols[i], 4'b0000);
            exp = sbq.pop_front();
            checks++;
            if (outv !== exp) begin
                errors++;
                $display("[TB] FAIL decode color %h: got %h required %h", cols[i], outv, exp);
            end
            lastExp = exp;
        end
    endtask

    task automatic test_alignment();
        logic [28:0] exp;
        logic [3:0]  sb;
        logic [8:0]  col;
        for (int i = 1; i <= 18; i++) begin
            sb  = 4'b0000;
            col = 9'h000;
            if (i >= 10 && i <= 14) sb[1] = 1'b1;
            if (i == 12 || i == 13) begin
                sb[0] = 1'b1;
                col   = 9'($urandom);
            end
            if (i == 16) sb[3:2] = 2'b11;
            strobe(col, sb);
            exp = sbq.pop_front();
            checks++;
            if (outv !== exp) begin
                errors++;
                $display("[TB] FAIL align strobe %0d: got %h required %h", i, outv, exp);
            end
            if (i == 10 || i == 11) begin
                checks++;
                if ({R, G, B} !== 24'hFFFFFF) begin
                    errors++;
                    $display("[TB] FAIL align_pre_blank strobe %0d: got %h required ffffff", i, {R, G, B});
                end
            end
            if (i == 12) begin
                checks++;
                if ({HB, R, G, B} !== {1'b1, 24'h000000}) begin
                    errors++;
                    $display("[TB] FAIL align_blank strobe 12: got %h required 1000000", {HB, R, G, B});
                end
            end
            lastExp = exp;
        end
    endtask

    task automatic test_stall();
        logic [28:0] exp;
        CLK5n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            COLOR = 9'($urandom);
            {HSYNC, VSYNC, HBLANK, VBLANK} = 4'($urandom);
            @(posedge CLK10);
            #1;
            checks++;
            if (outv !== lastExp) begin
                errors++;
                $display("[TB] FAIL stall cycle %0d: got %h required %h", i, outv, lastExp);
            end
        end
        for (int i = 0; i < 4; i++) begin
            strobe(9'($urandom), 4'b0000);
            exp = sbq.pop_front();
            checks++;
            if (outv !== exp) begin
                errors++;
                $display("[TB] FAIL after_stall strobe %0d: got %h required %h", i, outv, exp);
            end
            lastExp = exp;
        end
    endtask

    task automatic test_midline_reset();
        logic [28:0] exp;
        for (int i = 0; i < 2; i++) begin
            strobe(9'h000, 4'b0000);
            exp = sbq.pop_front();
            checks++;
            if (outv !== exp) begin
                errors++;
                $display("[TB] FAIL pre_reset strobe %0d: got %h required %h", i, outv, exp);
            end
        end
        RESETn = 1'b0;
        CLK5n  = 1'b1;
        @(posedge CLK10);
        #1;
        checks++;
        if (outv !== RST_OUT) begin
            errors++;
            $display("[TB] FAIL midline_reset: got %h required %h", outv, RST_OUT);
        end
        RESETn = 1'b1;
        model_reset();
        for (int i = 0; i < DELAY + 2; i++) begin
            strobe(9'h000, 4'b0000);
            exp = sbq.pop_front();
            checks++;
            if (outv !== exp) begin
                errors++;
                $display("[TB] FAIL refill strobe %0d: got %h required %h", i, outv, exp);
            end
            lastExp = exp;
        end
    endtask

`ifdef COLOR_OUT_SCANDIM_EN
    task automatic test_scandim();
        logic [28:0] exp;
        logic [3:0]  sb;
        // Three lines, then a frame blank, then one more line; each line 5 active + 2 blank strobes.
        for (int i = 0; i < 30; i++) begin
            sb = 4'b0000;
            if ((i % 7) >= 5) sb[1] = 1'b1;
            if (i >= 19 && i <= 22) sb[1:0] = 2'b11;
            strobe(9'h000, sb);
            exp = sbq.pop_front();
            checks++;
            if (outv !== exp) begin
                errors++;
                $display("[TB] FAIL scandim strobe %0d: got %h required %h", i, outv, exp);
            end
            lastExp = exp;
        end
    endtask
`endif

    initial begin
        checks = 0;
        errors = 0;
        expTab[0] = 8'h00; expTab[1] = 8'h24; expTab[2] = 8'h49; expTab[3] = 8'h6D;
        expTab[4] = 8'h92; expTab[5] = 8'hB6; expTab[6] = 8'hDB; expTab[7] = 8'hFF;
        RESETn = 1'b0;
        CLK5n  = 1'b1;
        COLOR  = 9'h000;
        {HSYNC, VSYNC, HBLANK, VBLANK} = 4'b0000;
        model_reset();
        @(posedge CLK10);
        #1;
        test_reset();
        test_decode();
        test_alignment();
        test_stall();
        test_midline_reset();
`ifdef COLOR_OUT_SCANDIM_EN
        test_scandim();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
